// File: rtl/dct_pkg.sv
// Shared constants and helpers for the 8-point DCT/IDCT stages.
// coef() is the one place the cosine basis lives, so the RTL and the models agree.
package dct_pkg;
    localparam int BWC      = 8;
    localparam int SCALE_SH = 7;
    localparam int ROUND    = 64;

    // Quarter-wave cosine table, 64*cos(i*pi/16) rounded, i = 0..8
    function automatic int aTab(input int i);
        case (i)
            0:       return 64;
            1:       return 63;
            2:       return 59;
            3:       return 53;
            4:       return 45;
            5:       return 36;
            6:       return 24;
            7:       return 12;
            default: return 0;
        endcase
    endfunction

    function automatic int coef(input int n, input int k);
        int m;
        if (k == 0) begin
            return 45;
        end
        m = ((2 * n + 1) * k) % 32;
        if (m <= 8) begin
            return aTab(m);
        end else if (m <= 16) begin
            return -aTab(16 - m);
        end else if (m <= 24) begin
            return -aTab(m - 16);
        end
        return aTab(32 - m);
    endfunction

    function automatic int sat(input int r, input int bw);
        int lo;
        int hi;
        lo = -(1 << (bw - 1));
        hi = (1 << (bw - 1)) - 1;
        if (r < lo) begin
            return lo;
        end else if (r > hi) begin
            return hi;
        end
        return r;
    endfunction
endpackage

// File: rtl/idct_mac_lane.sv
// One output lane of the serial IDCT: multiply-accumulate over the block, then
// round/saturate into a single output-buffer entry when the eighth coefficient arrives.
module idct_mac_lane
    import dct_pkg::*;
#(
    parameter int N   = 0,
    parameter int BWi = 10,
    parameter int BWo = 9,
    parameter int BWc = BWC,
    parameter int BWa = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic [2:0]            i_k,
    input  logic signed [BWi-1:0] i_x,
    output logic signed [BWo-1:0] o_sample
);

    // Column N of the basis, folded to constants at elaboration
    localparam logic signed [BWc-1:0] C0 = BWc'(coef(N, 0));
    localparam logic signed [BWc-1:0] C1 = BWc'(coef(N, 1));
    localparam logic signed [BWc-1:0] C2 = BWc'(coef(N, 2));
    localparam logic signed [BWc-1:0] C3 = BWc'(coef(N, 3));
    localparam logic signed [BWc-1:0] C4 = BWc'(coef(N, 4));
    localparam logic signed [BWc-1:0] C5 = BWc'(coef(N, 5));
    localparam logic signed [BWc-1:0] C6 = BWc'(coef(N, 6));
    localparam logic signed [BWc-1:0] C7 = BWc'(coef(N, 7));

    logic signed [BWc-1:0] w_coef;
    logic signed [BWa-1:0] w_prod;
    logic signed [BWa-1:0] w_sum;
    logic signed [BWa-1:0] w_rnd;
    logic signed [BWo-1:0] w_sat;
    logic signed [BWa-1:0] r_acc;
    logic signed [BWo-1:0] r_obuf;

    always_comb begin
        w_coef = C0;
        case (i_k)
            3'd0:    w_coef = C0;
            3'd1:    w_coef = C1;
            3'd2:    w_coef = C2;
            3'd3:    w_coef = C3;
            3'd4:    w_coef = C4;
            3'd5:    w_coef = C5;
            3'd6:    w_coef = C6;
            default: w_coef = C7;
        endcase
    end

    assign w_prod = BWa'(i_x) * BWa'(w_coef);
    assign w_sum  = r_acc + w_prod;
    assign w_rnd  = (w_sum + BWa'(ROUND)) >>> SCALE_SH;
    assign w_sat  = BWo'(sat(int'(w_rnd), BWo));

    // The accumulator clears on the completing edge so the next block starts clean
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_obuf <= '0;
        end else if (enb) begin
            if (i_k == 3'd7) begin
                r_obuf <= w_sat;
                r_acc  <= '0;
            end else begin
                r_acc  <= w_sum;
            end
        end
    end

    assign o_sample = r_obuf;

endmodule

// File: rtl/idct_1d.sv
// Serial 8-point 1-D inverse DCT: one coefficient in and one sample of the
// previous block out per enabled cycle.
module idct_1d
    import dct_pkg::*;
#(
    parameter int BWi = 10,
    parameter int BWo = 9,
    parameter int BWc = BWC,
    parameter int BWa = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic signed [BWi-1:0] idct_in,
    output logic signed [BWo-1:0] idct_out,
    output logic                  out_valid
);

    logic [2:0]            r_inCnt;
    logic                  r_outValid;
    logic signed [BWo-1:0] w_samples [0:7];

    for (genvar n = 0; n < 8; n++) begin : g_lane
        idct_mac_lane #(
            .N   (n),
            .BWi (BWi),
            .BWo (BWo),
            .BWc (BWc),
            .BWa (BWa)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .enb      (enb),
            .i_k      (r_inCnt),
            .i_x      (idct_in),
            .o_sample (w_samples[n])
        );
    end

    // The input counter doubles as the output read pointer for the previous block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inCnt    <= '0;
            r_outValid <= 1'b0;
        end else if (enb) begin
            r_inCnt <= r_inCnt + 3'd1;
            if (r_inCnt == 3'd7) begin
                r_outValid <= 1'b1;
            end
        end
    end

    assign idct_out  = w_samples[r_inCnt];
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_idct_1d.sv
// Testbench for idct_1d: table-driven blocks feed a scoreboard of expected
// samples that is drained one entry per enabled edge.
module tb_idct_1d;

    logic              clk = 1'b0;
    logic              rst;
    logic              enb;
    logic signed [9:0] idct_in;
    logic signed [8:0] idct_out;
    logic              out_valid;

    typedef struct {
        int x[8];
        int e[8];
        int nExp;
    } vec_t;

    typedef struct {
        int val;
        int blk;
        int n;
    } sbItem_t;

    vec_t    vecs[6];
    sbItem_t sbq[$];
    int      errors = 0;
    int      checks = 0;
    int      mCnt = 0;
    int      mValid = 0;
    int      mBlock[8];
    int      lastExp = 0;
    int      blkCount = 0;
    int      nOver = 0;
    int      expOver[8];

    idct_1d dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .idct_in   (idct_in),
        .idct_out  (idct_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic int benchA(input int i);
        int t[9] = '{64, 63, 59, 53, 45, 36, 24, 12, 0};
        return t[i];
    endfunction

    function automatic int benchC(input int n, input int k);
        int m;
        if (k == 0) return 45;
        m = ((2 * n + 1) * k) % 32;
        if (m <= 8)  return benchA(m);
        if (m <= 16) return -benchA(16 - m);
        if (m <= 24) return -benchA(m - 16);
        return benchA(32 - m);
    endfunction

    function automatic int golden(input int n);
        int s;
        int r;
        s = 0;
        for (int k = 0; k < 8; k++) s += mBlock[k] * benchC(n, k);
        r = (s + 64) >>> 7;
        if (r > 255)  r = 255;
        if (r < -256) r = -256;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int x, input bit e);
        sbItem_t item;
        @(negedge clk);
        idct_in = 10'(x);
        enb     = e;
        @(posedge clk);
        #1;
        if (e) begin
            mBlock[mCnt] = x;
            if (mCnt == 7) begin
                for (int n = 0; n < 8; n++) begin
                    item.val = (n < nOver) ? expOver[n] : golden(n);
                    item.blk = blkCount;
                    item.n   = n;
                    sbq.push_back(item);
                end
                blkCount++;
                mCnt   = 0;
                mValid = 1;
            end else begin
                mCnt++;
            end
            if (sbq.size() > 0) begin
                item    = sbq.pop_front();
                lastExp = item.val;
                checkOutput($sformatf("blk%0d.x%0d", item.blk, item.n), int'(idct_out), item.val);
            end else if (mValid == 0) begin
                checkOutput("idle zero", int'(idct_out), 0);
            end
        end else begin
            checkOutput("hold while enb low", int'(idct_out), lastExp);
        end
        checkOutput("out_valid", int'(out_valid), mValid);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst     = 1'b1;
        enb     = 1'b1;
        idct_in = 10'sd77;
        @(posedge clk);
        #1;
        mCnt    = 0;
        mValid  = 0;
        lastExp = 0;
        sbq.delete();
        checkOutput("reset idct_out", int'(idct_out), 0);
        checkOutput("reset out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        enb = 1'b0;
    endtask

    task automatic driveVector(input int idx, input int maxStall);
        int stalls;
        nOver   = vecs[idx].nExp;
        expOver = vecs[idx].e;
        for (int k = 0; k < 8; k++) begin
            stalls = (maxStall > 0) ? $urandom_range(0, maxStall) : 0;
            repeat (stalls) applyStimulus(int'($urandom_range(0, 1023)) - 512, 1'b0);
            applyStimulus(vecs[idx].x[k], 1'b1);
        end
        nOver = 0;
    endtask

    initial begin
        rst     = 1'b0;
        enb     = 1'b0;
        idct_in = '0;

        vecs[0].x = '{64, 0, 0, 0, 0, 0, 0, 0};
        vecs[0].e = '{23, 23, 23, 23, 23, 23, 23, 23};
        vecs[0].nExp = 8;
        vecs[1].x = '{0, 100, 0, 0, 0, 0, 0, 0};
        vecs[1].e = '{49, 41, 28, 9, -9, -28, -41, -49};
        vecs[1].nExp = 8;
        vecs[2].x = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].e = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].nExp = 8;
        vecs[3].x = '{511, 511, 511, 511, 511, 511, 511, 511};
        vecs[3].e = '{255, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].nExp = 1;
        vecs[4].x = '{-512, -512, -512, -512, -512, -512, -512, -512};
        vecs[4].e = '{-256, 0, 0, 0, 0, 0, 0, 0};
        vecs[4].nExp = 1;
        vecs[5].x = '{-300, 200, -50, 17, 0, -128, 99, 5};
        vecs[5].e = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].nExp = 0;

        doReset();

        // Back-to-back blocks with enb held high, including saturating inputs
        for (int v = 0; v < 6; v++) driveVector(v, 0);

        // DC block with a 1,0,0,1,... enable pattern, then random stalls
        nOver   = vecs[0].nExp;
        expOver = vecs[0].e;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[0].x[k], 1'b1);
            if (k < 7) begin
                applyStimulus(-1, 1'b0);
                applyStimulus(300, 1'b0);
            end
        end
        nOver = 0;
        driveVector(0, 3);
        driveVector(1, 2);
        driveVector(2, 2);

        // Abort the second block after four coefficients
        driveVector(0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(vecs[1].x[k], 1'b1);
        doReset();
        driveVector(0, 0);
        for (int k = 0; k < 7; k++) applyStimulus(0, 1'b1);

        if (sbq.size() != 0) begin
            checkOutput("scoreboard drained", sbq.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
